// File: rtl/block_pe_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : block_pe_gen_pkg
// Description : Shared types and constants for the block_pe_gen CGRA PE.
//               Holds the ALU op encoding and helper functions that size the
//               operand selectors and lay out the serial config word.
//               The layout, from MSB to LSB, is:
//               const | acc_len | op | sel_b | sel_a
// Revision    : 1.0 - initial release
// ============================================================================
package block_pe_gen_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_SLT  = 4'd8,
        OP_MAX  = 4'd9,
        OP_PASS = 4'd10,
        OP_ACC  = 4'd11
    } op_e;

    // Each selector picks from NUM_IN ports, the constant and the feedback.
    function automatic int calc_sel_w(input int num_in);
        return $clog2(num_in + 2);
    endfunction

    function automatic int calc_cfg_w(input int data_w, input int num_in, input int acc_len_w);
        return data_w + acc_len_w + OP_W + 2 * calc_sel_w(num_in);
    endfunction

    // Field offsets within the config word.
    localparam int CFG_OFF_SEL_A = 0;

    function automatic int cfg_off_sel_b(input int sel_w);
        return sel_w;
    endfunction

    function automatic int cfg_off_op(input int sel_w);
        return 2 * sel_w;
    endfunction

    function automatic int cfg_off_acc_len(input int sel_w);
        return 2 * sel_w + OP_W;
    endfunction

    function automatic int cfg_off_const(input int sel_w, input int acc_len_w);
        return 2 * sel_w + OP_W + acc_len_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/block_pe_gen_alu.sv
`default_nettype none
// ============================================================================
// Module      : block_pe_gen_alu
// Description : Combinational multi-op ALU for the block_pe_gen PE.
//               Accumulate sequencing lives in the top; OP_ACC simply
//               forwards operand a here.
// Ports       : i_a, i_b   - operands (DATA_W)
//               i_op       - operation code (OP_W)
//               o_result   - result, modulo 2^DATA_W (DATA_W)
// Revision    : 1.0 - initial release
// ============================================================================
module block_pe_gen_alu
    import block_pe_gen_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [OP_W-1:0]   i_op,
    output logic [DATA_W-1:0] o_result
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] w_shamt;
    logic            w_lt;

    // Shift amount uses only the low bits of b, so b=33 on 32 bits shifts by 1.
    assign w_shamt = i_b[SH_W-1:0];
    assign w_lt    = $signed(i_a) < $signed(i_b);

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_MUL:  o_result = i_a * i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SHL:  o_result = i_a << w_shamt;
            OP_SHR:  o_result = i_a >> w_shamt;
            OP_SLT:  o_result = {{(DATA_W-1){1'b0}}, w_lt};
            OP_MAX:  o_result = w_lt ? i_b : i_a;
            OP_PASS: o_result = i_a;
            OP_ACC:  o_result = i_a;
            default: o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/block_pe_gen.sv
`default_nettype none
// ============================================================================
// Module      : block_pe_gen
// Description : Parametrised CGRA processing element. Operand crossbar
//               (ports / constant / feedback), multi-op ALU with accumulate
//               mode, registered valid/ready output, serial config chain.
// Ports       : clk, reset (async, active-low)
//               config_en, config_in, config_out - serial config chain
//               in_data, in_valid, in_ready       - input bundle
//               out_data, out_valid, out_ready    - result
//               perf_fire_cnt, perf_stall_cnt     - performance counters
// Options     : BLOCK_PE_GEN_PERF_EN - enables the performance counters;
//               when undefined both counter ports are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module block_pe_gen
    import block_pe_gen_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_IN    = 2,
    parameter int ACC_LEN_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     config_en,
    input  logic                     config_in,
    output logic                     config_out,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              perf_fire_cnt,
    output logic [31:0]              perf_stall_cnt
);

    localparam int SEL_W          = calc_sel_w(NUM_IN);
    localparam int CFG_W          = calc_cfg_w(DATA_W, NUM_IN, ACC_LEN_W);
    localparam int c_off_sel_b    = cfg_off_sel_b(SEL_W);
    localparam int c_off_op       = cfg_off_op(SEL_W);
    localparam int c_off_acc_len  = cfg_off_acc_len(SEL_W);
    localparam int c_off_const    = cfg_off_const(SEL_W, ACC_LEN_W);

    logic [CFG_W-1:0]     r_cfg;
    logic [DATA_W-1:0]    r_acc;
    logic [ACC_LEN_W-1:0] r_cnt;
    logic [DATA_W-1:0]    r_out_data;
    logic                 r_out_valid;

    logic [SEL_W-1:0]     w_sel_a;
    logic [SEL_W-1:0]     w_sel_b;
    logic [OP_W-1:0]      w_op;
    logic [ACC_LEN_W-1:0] w_acc_len;
    logic [DATA_W-1:0]    w_const;
    logic [DATA_W-1:0]    w_a;
    logic [DATA_W-1:0]    w_b;
    logic [DATA_W-1:0]    w_alu;
    logic [DATA_W-1:0]    w_acc_sum;
    logic [ACC_LEN_W-1:0] w_len_eff;
    logic [ACC_LEN_W-1:0] w_cnt_next;
    logic                 w_is_acc;
    logic                 w_acc_done;
    logic                 w_fire;

    assign w_sel_a   = r_cfg[CFG_OFF_SEL_A +: SEL_W];
    assign w_sel_b   = r_cfg[c_off_sel_b   +: SEL_W];
    assign w_op      = r_cfg[c_off_op      +: OP_W];
    assign w_acc_len = r_cfg[c_off_acc_len +: ACC_LEN_W];
    assign w_const   = r_cfg[c_off_const   +: DATA_W];

    // Operand crossbar: ports, then constant, then feedback; spare codes give 0.
    function automatic logic [DATA_W-1:0] f_pick(
        input logic [SEL_W-1:0]         sel,
        input logic [NUM_IN*DATA_W-1:0] ports,
        input logic [DATA_W-1:0]        cval,
        input logic [DATA_W-1:0]        fb
    );
        logic [DATA_W-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(sel) == k) v = ports[k*DATA_W +: DATA_W];
        end
        if (int'(sel) == NUM_IN)     v = cval;
        if (int'(sel) == NUM_IN + 1) v = fb;
        return v;
    endfunction

    assign w_a = f_pick(w_sel_a, in_data, w_const, r_out_data);
    assign w_b = f_pick(w_sel_b, in_data, w_const, r_out_data);

    block_pe_gen_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_a      (w_a),
        .i_b      (w_b),
        .i_op     (w_op),
        .o_result (w_alu)
    );

    assign in_ready   = !config_en && (!r_out_valid || out_ready);
    assign w_fire     = in_valid && in_ready;
    assign config_out = r_cfg[CFG_W-1];
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;

    // A zero length behaves as one beat, i.e. a plain pass-through.
    assign w_is_acc   = (w_op == OP_ACC);
    assign w_len_eff  = (w_acc_len == '0) ? {{(ACC_LEN_W-1){1'b0}}, 1'b1} : w_acc_len;
    assign w_cnt_next = r_cnt + 1'b1;
    assign w_acc_done = (w_cnt_next == w_len_eff);
    assign w_acc_sum  = r_acc + w_a;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cfg       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (config_en) begin
            // Datapath frozen while shifting; a pending result may still drain.
            r_cfg <= {r_cfg[CFG_W-2:0], config_in};
            r_acc <= '0;
            r_cnt <= '0;
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
        end else if (w_fire) begin
            if (w_is_acc) begin
                if (w_acc_done) begin
                    r_out_data  <= w_acc_sum;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_acc_sum;
                    r_cnt <= w_cnt_next;
                    // Fire implies any pending result is being consumed now.
                    if (r_out_valid && out_ready) r_out_valid <= 1'b0;
                end
            end else begin
                r_out_data  <= w_alu;
                r_out_valid <= 1'b1;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef BLOCK_PE_GEN_PERF_EN
    logic [31:0] r_perf_fire;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_fire  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_fire)                    r_perf_fire  <= r_perf_fire + 32'd1;
            if (r_out_valid && !out_ready) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fire_cnt  = r_perf_fire;
    assign perf_stall_cnt = r_perf_stall;
`else
    assign perf_fire_cnt  = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule
`default_nettype wire
